// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared constants, opcode and state encodings for the HI/LO unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int WIDTH = 24;
  localparam int OP_W  = 2;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [OP_W-1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit_if
// Brief    : CPU-side operand/command and HI/LO result bundle for the unit.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_unit_if;
  import muldiv_pkg::*;

  logic             start;
  logic [OP_W-1:0]  opsel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, opsel, a, b, write_hi, write_lo, write_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, opsel, a, b, write_hi, write_lo, write_data,
    output hi, lo, busy, done, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One iteration of shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic               is_div_i,
  input  logic [2*WIDTH:0]   work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   work_o
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH+1:0] w_trial;

  // work_i holds {upper 25 bits, lower 24 bits}: accumulator|multiplier or
  // partial remainder|dividend-becoming-quotient.
  always_comb begin
    w_sum       = work_i[2*WIDTH:WIDTH] + (work_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    w_rem_shift = {work_i[2*WIDTH-1:WIDTH], work_i[WIDTH-1]};
    w_trial     = {1'b0, w_rem_shift} - {2'b00, opnd_i};
    if (is_div_i) begin
      work_o = {(w_trial[WIDTH+1] ? w_rem_shift : w_trial[WIDTH:0]),
                work_i[WIDTH-2:0], ~w_trial[WIDTH+1]};
    end else begin
      work_o = {1'b0, w_sum, work_i[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Brief    : Iterative 24-bit multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  hilo_muldiv_unit_if.slave    bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               w_accept;
  logic               w_muls;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_res;
  logic [2*WIDTH:0]   w_step;

  muldiv_step u_step (
    .is_div_i (is_div_q),
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .work_o   (w_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    w_accept = bus.start && (state_q == IDLE) && (bus.opsel != OP_RSVD);
    w_muls   = (bus.opsel == OP_MULS);
    w_abs_a  = (w_muls && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_abs_b  = (w_muls && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    w_res    = neg_q ? -work_q[2*WIDTH-1:0] : work_q[2*WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.write_hi) hi_d = bus.write_data;
        if (bus.write_lo) lo_d = bus.write_data;
        if (w_accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = (bus.opsel == OP_DIVU);
          neg_d    = w_muls && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          dbz_d    = (bus.opsel == OP_DIVU) && (bus.b == '0);
          // Multiplier rides in the low half; dividend shifts out of it.
          if (bus.opsel == OP_DIVU) begin
            work_d = {{(WIDTH+1){1'b0}}, bus.a};
            opnd_d = bus.b;
          end else begin
            work_d = {{(WIDTH+1){1'b0}}, w_abs_b};
            opnd_d = w_abs_a;
          end
        end
      end
      RUN: begin
        work_d = w_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = w_res[2*WIDTH-1:WIDTH];
        lo_d    = w_res[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Brief    : Directed self-checking bench for the HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hilo_muldiv_unit_if bus ();

  hilo_muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble operands after accept, then check the
  // busy window, HI/LO stability while running, the done pulse and results.
  task automatic run_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] exp_hi, input logic [23:0] exp_lo,
                        input logic exp_dbz, input bit inject, input string tag);
    int          n;
    logic [23:0] hi0;
    logic [23:0] lo0;
    bit          stable;
    @(negedge clk);
    bus.start = 1'b1; bus.opsel = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.opsel = 2'b00; bus.a = 24'h5A5A5A; bus.b = 24'hA5A5A5;
    @(negedge clk);
    check({tag, "_dbz_at_accept"}, 48'(bus.div_by_zero), 48'(exp_dbz));
    hi0 = bus.hi; lo0 = bus.lo; stable = 1'b1; n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (bus.hi !== hi0 || bus.lo !== lo0 || bus.done !== 1'b0) stable = 1'b0;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.opsel = OP_DIVU; bus.a = 24'h000005; bus.b = 24'h000000;
        bus.write_hi = 1'b1; bus.write_data = 24'h111111;
      end
      if (inject && n == 6) begin
        bus.start = 1'b0; bus.write_hi = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 48'(n), 48'd25);
    check({tag, "_stable_in_run"}, 48'(stable), 48'd1);
    check({tag, "_done"}, 48'(bus.done), 48'd1);
    check({tag, "_hi"}, 48'(bus.hi), 48'(exp_hi));
    check({tag, "_lo"}, 48'(bus.lo), 48'(exp_lo));
    check({tag, "_dbz"}, 48'(bus.div_by_zero), 48'(exp_dbz));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 48'(bus.done), 48'd0);
  endtask

  initial begin
    bit nodone;
    checks = 0; failures = 0;
    bus.start = 1'b0; bus.opsel = 2'b00; bus.a = '0; bus.b = '0;
    bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", 48'(bus.hi), 48'd0);
    check("reset_lo", 48'(bus.lo), 48'd0);
    check("reset_busy", 48'(bus.busy), 48'd0);
    check("reset_done", 48'(bus.done), 48'd0);
    check("reset_dbz", 48'(bus.div_by_zero), 48'd0);
    rst = 1'b0;

    run_op(OP_MULU, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'h000001, 1'b0, 1'b0, "mulu_max");
    run_op(OP_MULS, 24'hFFFFFF, 24'h000003, 24'hFFFFFF, 24'hFFFFFD, 1'b0, 1'b0, "muls_neg");
    run_op(OP_MULS, 24'h800000, 24'h800000, 24'h400000, 24'h000000, 1'b0, 1'b0, "muls_min");
    run_op(OP_DIVU, 24'h000064, 24'h000007, 24'h000002, 24'h00000E, 1'b0, 1'b0, "divu_100_7");
    run_op(OP_DIVU, 24'h123456, 24'h000000, 24'h123456, 24'hFFFFFF, 1'b1, 1'b0, "divu_zero");

    // Reserved opcode is ignored and leaves the sticky flag alone.
    @(negedge clk);
    bus.start = 1'b1; bus.opsel = OP_RSVD; bus.a = 24'h1; bus.b = 24'h1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rsvd_busy", 48'(bus.busy), 48'd0);
    check("rsvd_dbz", 48'(bus.div_by_zero), 48'd1);
    check("rsvd_hi", 48'(bus.hi), 48'h123456);

    run_op(OP_MULU, 24'h000010, 24'h000020, 24'h000000, 24'h000200, 1'b0, 1'b0, "mulu_clr_dbz");
    run_op(OP_MULU, 24'h001000, 24'h000100, 24'h000000, 24'h100000, 1'b0, 1'b1, "busy_ignore");

    // Reset at RUN iteration 10 aborts the operation with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.opsel = OP_MULU; bus.a = 24'h000123; bus.b = 24'h000456;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 48'(bus.busy), 48'd0);
    check("abort_hi", 48'(bus.hi), 48'd0);
    check("abort_lo", 48'(bus.lo), 48'd0);
    nodone = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) nodone = 1'b0;
      @(negedge clk);
    end
    check("abort_no_done", 48'(nodone), 48'd1);

    // Direct HI/LO writes in IDLE.
    bus.write_hi = 1'b1; bus.write_data = 24'hABCDEF;
    @(negedge clk);
    bus.write_hi = 1'b0;
    check("mthi_hi", 48'(bus.hi), 48'hABCDEF);
    check("mthi_lo", 48'(bus.lo), 48'd0);
    check("mthi_done", 48'(bus.done), 48'd0);
    bus.write_lo = 1'b1; bus.write_data = 24'h000042;
    @(negedge clk);
    bus.write_lo = 1'b0;
    check("mtlo_lo", 48'(bus.lo), 48'h000042);
    check("mtlo_hi", 48'(bus.hi), 48'hABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
